pipelined_node_link: RTL and testbench

// - Registered, parametrised link between a node/NI port and a router port.
// - Retimes long wires: the forward path (flit, valid) and the backward path (per-VC on/off, allocatable) each get a configurable register depth.
// - Bit-for-bit transparent; adds only latency. Depth 0 on a path = combinational pass-through on that path.
// - Sits between router2router interfaces at mesh boundaries and on inter-tile hops.

---
 rtl/pipelined_node_link_pkg.sv | 28 ++
 rtl/pipelined_node_link_if.sv | 25 ++
 rtl/pipelined_node_link_pipe.sv | 43 ++++
 rtl/pipelined_node_link.sv | 114 +++++++++++
 tb/tb_pipelined_node_link.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_node_link_pkg.sv
// Shared NoC link types: flit layout, VC count, backward bundle.
// Imported by the link interface, pipe and top.
package noc_params;

  localparam int VC_NUM = 4;
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int PAYLOAD_W = 32;
  localparam int LINK_MAX_STAGES = 4;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [VC_SIZE-1:0] vc_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic [VC_NUM-1:0] on_off;
    logic [VC_NUM-1:0] alloc;
  } bwd_t;

endpackage

// File: rtl/pipelined_node_link_if.sv
// router2router: flit/valid forward, per-VC on_off/allocatable back.
// upstream drives the flit; downstream drives the VC state.
interface router2router;
  import noc_params::*;

  flit_t data;
  logic is_valid;
  logic [VC_NUM-1:0] is_on_off;
  logic [VC_NUM-1:0] is_allocatable;

  modport upstream (
    output data,
    output is_valid,
    input  is_on_off,
    input  is_allocatable
  );

  modport downstream (
    input  data,
    input  is_valid,
    output is_on_off,
    output is_allocatable
  );

endinterface

// File: rtl/pipelined_node_link_pipe.sv
// link_pipe_stage: DEPTH-deep shift register, DEPTH=0 is a wire.
// Ports: clk, rst (async low), valid_i/data_i in, valid_o/data_o out.
module link_pipe_stage #(
  parameter type T = logic,
  parameter int DEPTH = 1,
  parameter bit GATED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  T     data_i,
  output logic valid_o,
  output T     data_o
);

  if (DEPTH == 0) begin : g_wire
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_regs
    logic [DEPTH-1:0] vld_q;
    T data_q [DEPTH];

    // With GATED set, a data stage only loads behind a valid flit,
    // so idle cycles leave the register (and its wires) quiet.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else begin
        vld_q[0] <= valid_i;
        if (!GATED || valid_i) data_q[0] <= data_i;
        for (int k = 1; k < DEPTH; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (!GATED || vld_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/pipelined_node_link.sv
// Registered node<->router link; optional counters: NODE_LINK_STATS_EN.
// Ports: clk, rst, router_if_up/down, node-side flit + VC state, stats.
module pipelined_node_link
  import noc_params::*;
#(
  parameter int FWD_STAGES = 1,
  parameter int BWD_STAGES = 1,
  parameter int STAT_W = 32
) (
  input  logic clk,
  input  logic rst,
  router2router.upstream   router_if_up,
  router2router.downstream router_if_down,
  input  flit_t data_i,
  input  logic  is_valid_i,
  output logic [VC_NUM-1:0] is_on_off_o,
  output logic [VC_NUM-1:0] is_allocatable_o,
  output flit_t data_o,
  output logic  is_valid_o,
  input  logic [VC_NUM-1:0] is_on_off_i,
  input  logic [VC_NUM-1:0] is_allocatable_i
`ifdef NODE_LINK_STATS_EN
  ,
  input  logic stats_clear_i,
  output logic [STAT_W-1:0] flit_cnt_o,
  output logic [STAT_W-1:0] stall_cnt_o
`endif
);

  localparam int FWD_D =
    (FWD_STAGES > LINK_MAX_STAGES) ? LINK_MAX_STAGES : FWD_STAGES;
  localparam int BWD_D =
    (BWD_STAGES > LINK_MAX_STAGES) ? LINK_MAX_STAGES : BWD_STAGES;

  bwd_t bwd_up_in, bwd_up_out;
  bwd_t bwd_dn_in, bwd_dn_out;
  // Backward pipes reuse the generic pipe; their valid lane is idle.
  logic unused_vld_up, unused_vld_dn;

  assign bwd_up_in.on_off = router_if_up.is_on_off;
  assign bwd_up_in.alloc  = router_if_up.is_allocatable;
  assign bwd_dn_in.on_off = is_on_off_i;
  assign bwd_dn_in.alloc  = is_allocatable_i;

  assign is_on_off_o      = bwd_up_out.on_off;
  assign is_allocatable_o = bwd_up_out.alloc;
  assign router_if_down.is_on_off      = bwd_dn_out.on_off;
  assign router_if_down.is_allocatable = bwd_dn_out.alloc;

  link_pipe_stage #(.T(flit_t), .DEPTH(FWD_D), .GATED(1'b1)) u_fwd_up (
    .clk(clk),
    .rst(rst),
    .valid_i(is_valid_i),
    .data_i(data_i),
    .valid_o(router_if_up.is_valid),
    .data_o(router_if_up.data)
  );

  link_pipe_stage #(.T(flit_t), .DEPTH(FWD_D), .GATED(1'b1)) u_fwd_dn (
    .clk(clk),
    .rst(rst),
    .valid_i(router_if_down.is_valid),
    .data_i(router_if_down.data),
    .valid_o(is_valid_o),
    .data_o(data_o)
  );

  link_pipe_stage #(.T(bwd_t), .DEPTH(BWD_D), .GATED(1'b0)) u_bwd_up (
    .clk(clk),
    .rst(rst),
    .valid_i(1'b0),
    .data_i(bwd_up_in),
    .valid_o(unused_vld_up),
    .data_o(bwd_up_out)
  );

  link_pipe_stage #(.T(bwd_t), .DEPTH(BWD_D), .GATED(1'b0)) u_bwd_dn (
    .clk(clk),
    .rst(rst),
    .valid_i(1'b0),
    .data_i(bwd_dn_in),
    .valid_o(unused_vld_dn),
    .data_o(bwd_dn_out)
  );

`ifdef NODE_LINK_STATS_EN
  logic [1:0] flit_inc;
  logic stall;
  logic [STAT_W:0] flit_sum, stall_sum;

  // Count at the pipe entries so depth does not shift the tally.
  assign flit_inc  = {1'b0, is_valid_i} + {1'b0, router_if_down.is_valid};
  assign stall     = is_valid_i & ~is_on_off_o[data_i.vc_id];
  assign flit_sum  = {1'b0, flit_cnt_o} + {{(STAT_W-1){1'b0}}, flit_inc};
  assign stall_sum = {1'b0, stall_cnt_o} + {{STAT_W{1'b0}}, stall};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else if (stats_clear_i) begin
      flit_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      flit_cnt_o  <= flit_sum[STAT_W] ? '1 : flit_sum[STAT_W-1:0];
      stall_cnt_o <= stall_sum[STAT_W] ? '1 : stall_sum[STAT_W-1:0];
    end
  end
`else
  // Counter width is meaningless without the counters.
  localparam int STAT_W_UNUSED = STAT_W;
`endif

endmodule

// File: tb/tb_pipelined_node_link.sv
// Bench for pipelined_node_link: four depth configs side by side,
// checked against a delay-line reference and literal vector tables.
module tb_pipelined_node_link;
  import noc_params::*;

  localparam int N = 4;
  localparam int SW = 4;
  localparam logic [N-1:0][2:0] FWD_T = {3'd3, 3'd1, 3'd0, 3'd2};
  localparam logic [N-1:0][2:0] BWD_T = {3'd0, 3'd1, 3'd4, 3'd2};

  typedef struct packed {
    logic vld;
    flit_t f;
  } fwd_s;

  typedef struct packed {
    logic vld;
    logic [7:0] pay;
    logic [VC_NUM-1:0] on;
    logic [VC_NUM-1:0] al;
    logic e_vld;
    logic e_chk;
    logic [7:0] e_pay;
    logic [VC_NUM-1:0] e_on;
    logic [VC_NUM-1:0] e_al;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  flit_t in_flit, dn_flit;
  logic in_vld, dn_vld;
  logic [VC_NUM-1:0] up_on, up_al, in_on, in_al;

  flit_t o_up_data [N];
  flit_t o_data [N];
  logic o_up_vld [N];
  logic o_vld [N];
  logic [VC_NUM-1:0] o_on [N];
  logic [VC_NUM-1:0] o_al [N];
  logic [VC_NUM-1:0] o_dn_on [N];
  logic [VC_NUM-1:0] o_dn_al [N];
`ifdef NODE_LINK_STATS_EN
  logic stats_clr;
  logic [SW-1:0] o_fcnt [N];
  logic [SW-1:0] o_scnt [N];
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    router2router up_if ();
    router2router dn_if ();

    assign up_if.is_on_off = up_on;
    assign up_if.is_allocatable = up_al;
    assign dn_if.data = dn_flit;
    assign dn_if.is_valid = dn_vld;
    assign o_up_data[g] = up_if.data;
    assign o_up_vld[g] = up_if.is_valid;
    assign o_dn_on[g] = dn_if.is_on_off;
    assign o_dn_al[g] = dn_if.is_allocatable;

    pipelined_node_link #(
      .FWD_STAGES(int'(FWD_T[g])),
      .BWD_STAGES(int'(BWD_T[g])),
      .STAT_W(SW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .router_if_up(up_if),
      .router_if_down(dn_if),
      .data_i(in_flit),
      .is_valid_i(in_vld),
      .is_on_off_o(o_on[g]),
      .is_allocatable_o(o_al[g]),
      .data_o(o_data[g]),
      .is_valid_o(o_vld[g]),
      .is_on_off_i(in_on),
      .is_allocatable_i(in_al)
`ifdef NODE_LINK_STATS_EN
      ,
      .stats_clear_i(stats_clr),
      .flit_cnt_o(o_fcnt[g]),
      .stall_cnt_o(o_scnt[g])
`endif
    );
  end

  // Reference: each output is its input delayed by the path depth,
  // where anything sampled before the end of reset counts as zero.
  fwd_s up_h [LINK_MAX_STAGES];
  fwd_s dn_h [LINK_MAX_STAGES];
  logic [VC_NUM-1:0] on_h [LINK_MAX_STAGES];
  logic [VC_NUM-1:0] al_h [LINK_MAX_STAGES];
  logic [VC_NUM-1:0] ion_h [LINK_MAX_STAGES];
  logic [VC_NUM-1:0] ial_h [LINK_MAX_STAGES];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LINK_MAX_STAGES; k++) begin
        up_h[k] <= '0;
        dn_h[k] <= '0;
        on_h[k] <= '0;
        al_h[k] <= '0;
        ion_h[k] <= '0;
        ial_h[k] <= '0;
      end
    end else begin
      for (int k = 1; k < LINK_MAX_STAGES; k++) begin
        up_h[k] <= up_h[k-1];
        dn_h[k] <= dn_h[k-1];
        on_h[k] <= on_h[k-1];
        al_h[k] <= al_h[k-1];
        ion_h[k] <= ion_h[k-1];
        ial_h[k] <= ial_h[k-1];
      end
      up_h[0] <= {in_vld, in_flit};
      dn_h[0] <= {dn_vld, dn_flit};
      on_h[0] <= up_on;
      al_h[0] <= up_al;
      ion_h[0] <= in_on;
      ial_h[0] <= in_al;
    end
  end

  task automatic chk(string name, int idx, logic [63:0] act,
                     logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  function automatic flit_t mk(logic [7:0] p);
    flit_t f;
    f = '0;
    f.flit_label = BODY;
    f.vc_id = VC_SIZE'(1);
    f.payload = {24'h0, p};
    return f;
  endfunction

  function automatic flit_t rnd_flit();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[$bits(flit_t)-1:0];
  endfunction

  task automatic check_all();
    for (int g = 0; g < N; g++) begin
      fwd_s eu, ed, cu, cd;
      logic [VC_NUM-1:0] eon, eal, edon, edal;
      int d, b;
      d = int'(FWD_T[g]);
      b = int'(BWD_T[g]);
      cu = {in_vld, in_flit};
      cd = {dn_vld, dn_flit};
      eu = (d == 0) ? cu : up_h[d-1];
      ed = (d == 0) ? cd : dn_h[d-1];
      eon = (b == 0) ? up_on : on_h[b-1];
      eal = (b == 0) ? up_al : al_h[b-1];
      edon = (b == 0) ? in_on : ion_h[b-1];
      edal = (b == 0) ? in_al : ial_h[b-1];
      chk("up_vld", g, 64'(o_up_vld[g]), 64'(eu.vld));
      if (eu.vld) chk("up_data", g, 64'(o_up_data[g]), 64'(eu.f));
      chk("dn_vld", g, 64'(o_vld[g]), 64'(ed.vld));
      if (ed.vld) chk("dn_data", g, 64'(o_data[g]), 64'(ed.f));
      chk("on_o", g, 64'(o_on[g]), 64'(eon));
      chk("al_o", g, 64'(o_al[g]), 64'(eal));
      chk("dn_on", g, 64'(o_dn_on[g]), 64'(edon));
      chk("dn_al", g, 64'(o_dn_al[g]), 64'(edal));
    end
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    in_vld = 1'($urandom);
    in_flit = rnd_flit();
    dn_vld = 1'($urandom);
    dn_flit = rnd_flit();
    up_on = VC_NUM'($urandom);
    up_al = VC_NUM'($urandom);
    in_on = VC_NUM'($urandom);
    in_al = VC_NUM'($urandom);
    #1;
  endtask

`ifdef NODE_LINK_STATS_EN
  task automatic stats_test();
    in_vld = 1'b0;
    dn_vld = 1'b0;
    up_on = '1;
    up_al = '1;
    in_flit = mk(8'h5A);
    repeat (3) @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    chk("st_clr_f", 0, 64'(o_fcnt[2]), 64'd0);
    chk("st_clr_s", 0, 64'(o_scnt[2]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_vld = 1'b1;
      dn_vld = (i < 3);
    end
    @(negedge clk);
    in_vld = 1'b0;
    dn_vld = 1'b0;
    #1;
    chk("st_flit8", 0, 64'(o_fcnt[2]), 64'd8);
    chk("st_nostall", 0, 64'(o_scnt[2]), 64'd0);
    up_on = 4'b1101;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_vld = 1'b1;
    end
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    chk("st_stall4", 0, 64'(o_scnt[2]), 64'd4);
    chk("st_flit12", 0, 64'(o_fcnt[2]), 64'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_vld = 1'b1;
      dn_vld = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("st_sat", 0, 64'(o_fcnt[2]), 64'd15);
    chk("st_stall9", 0, 64'(o_scnt[2]), 64'd9);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    chk("st_clrwin_f", 0, 64'(o_fcnt[2]), 64'd0);
    chk("st_clrwin_s", 0, 64'(o_scnt[2]), 64'd0);
    @(negedge clk);
    #1;
    chk("st_after_f", 0, 64'(o_fcnt[2]), 64'd2);
    chk("st_after_s", 0, 64'(o_scnt[2]), 64'd1);
    in_vld = 1'b0;
    dn_vld = 1'b0;
  endtask
`endif

  vec_t tv [6];
  int cnt [N];
  int first [N];
  int bad [N];

  initial begin
    tv[0] = '{1'b1, 8'h11, 4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'hF};
    tv[1] = '{1'b0, 8'hFF, 4'hF, 4'h3, 1'b1, 1'b1, 8'h11, 4'hF, 4'hF};
    tv[2] = '{1'b0, 8'hEE, 4'h2, 4'h3, 1'b0, 1'b1, 8'h11, 4'hF, 4'h3};
    tv[3] = '{1'b1, 8'h22, 4'h2, 4'h8, 1'b0, 1'b1, 8'h11, 4'h2, 4'h3};
    tv[4] = '{1'b0, 8'h33, 4'h2, 4'h8, 1'b1, 1'b1, 8'h22, 4'h2, 4'h8};
    tv[5] = '{1'b0, 8'h44, 4'h7, 4'h1, 1'b0, 1'b1, 8'h22, 4'h2, 4'h8};

    rst = 1'b0;
    in_vld = 1'b1;
    in_flit = mk(8'h3C);
    dn_vld = 1'b1;
    dn_flit = mk(8'hC3);
    up_on = '1;
    up_al = 4'h5;
    in_on = 4'hA;
    in_al = '1;
`ifdef NODE_LINK_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check_all();
`ifdef NODE_LINK_STATS_EN
    chk("rst_fcnt", 0, 64'(o_fcnt[2]), 64'd0);
    chk("rst_scnt", 0, 64'(o_scnt[2]), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted mid-traffic, then released.
    repeat (20) begin
      rand_cycle();
      check_all();
    end
    rand_cycle();
    #1 rst = 1'b0;
    #1;
    chk("t1_up_vld", 0, 64'(o_up_vld[0]), 64'd0);
    chk("t1_up_data", 0, 64'(o_up_data[0]), 64'd0);
    chk("t1_vld_o", 0, 64'(o_vld[0]), 64'd0);
    chk("t1_data_o", 0, 64'(o_data[0]), 64'd0);
    chk("t1_on_o", 0, 64'(o_on[0]), 64'd0);
    chk("t1_al_o", 0, 64'(o_al[0]), 64'd0);
    chk("t1_dn_on", 0, 64'(o_dn_on[0]), 64'd0);
    chk("t1_dn_al", 0, 64'(o_dn_al[0]), 64'd0);
    check_all();
    up_on = '1;
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1_hold0", 0, 64'(o_on[0]), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_hold1", 0, 64'(o_on[0]), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_track", 0, 64'(o_on[0]), 64'hF);

    // Latency sweep: ten back-to-back flits through every depth.
    in_vld = 1'b0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      cnt[g] = 0;
      first[g] = -1;
      bad[g] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_vld = (c < 10);
      in_flit = mk(8'hA5);
      #1;
      for (int g = 0; g < N; g++) begin
        if (o_up_vld[g]) begin
          cnt[g]++;
          if (first[g] < 0) first[g] = c;
          if (o_up_data[g] !== mk(8'hA5)) bad[g]++;
        end
      end
    end
    for (int g = 0; g < N; g++) begin
      chk("t2_count", g, 64'(cnt[g]), 64'd10);
      chk("t2_latency", g, 64'(first[g]), 64'(FWD_T[g]));
      chk("t2_payload", g, 64'(bad[g]), 64'd0);
    end

    // Bubbles and backward toggles on the single-stage link.
    in_vld = 1'b0;
    up_on = '1;
    up_al = '1;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      in_vld = tv[r].vld;
      in_flit = mk(tv[r].pay);
      up_on = tv[r].on;
      up_al = tv[r].al;
      #1;
      chk("tbl_vld", r, 64'(o_up_vld[2]), 64'(tv[r].e_vld));
      if (tv[r].e_chk)
        chk("tbl_data", r, 64'(o_up_data[2].payload), 64'(tv[r].e_pay));
      chk("tbl_on", r, 64'(o_on[2]), 64'(tv[r].e_on));
      chk("tbl_al", r, 64'(o_al[2]), 64'(tv[r].e_al));
    end

    // Concurrent random traffic in both directions.
    repeat (1000) begin
      rand_cycle();
      check_all();
    end

`ifdef NODE_LINK_STATS_EN
    stats_test();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
